des_key_sched_ctrl: RTL and testbench

- Sequencer for the DES key schedule. Accepts a 64-bit key and runs the PC1 permutation, then the per-round C/D rotations, then the PC2 permutation.
- Emits the 16 48-bit round subkeys one per handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Sits between the key input interface and the round datapath. The round engine consumes one subkey per round.

---
 rtl/des_key_sched_ctrl.sv | 147 ++++++++++++++
 tb/tb_des_key_sched_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched_ctrl.sv
// DES key schedule sequencer: PC1 on key acceptance, per-round C/D rotation, and PC2 on the
// current C/D register to emit the 16 round subkeys in encrypt or decrypt order.
module des_key_sched_ctrl #(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [0:63] key_in,
    input  logic        decrypt,
    input  logic        abort,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [0:47] subkey,
    output logic [3:0]  round_idx,
    output logic        last,
    output logic        key_err,
    output logic        busy
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    // Table entries are 1-based DES bit numbers.
    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_e      state_q, state_d;
    logic [0:55] cd_q, cd_d;
    logic        dec_q, dec_d;
    logic [3:0]  round_q, round_d;
    logic        key_err_q, key_err_d;

    logic [0:55] pc1_out;
    logic [0:47] pc2_out;
    logic [7:0]  byte_odd;
    logic        parity_ok;

    for (genvar i = 0; i < 56; i++) begin : g_pc1
        localparam int unsigned Src = PC1_TAB[i] - 1;
        assign pc1_out[i] = key_in[Src];
    end

    for (genvar i = 0; i < 48; i++) begin : g_pc2
        localparam int unsigned Src = PC2_TAB[i] - 1;
        assign pc2_out[i] = cd_q[Src];
    end

    for (genvar b = 0; b < 8; b++) begin : g_parity
        assign byte_odd[b] = ^key_in[8*b +: 8];
    end

    assign parity_ok = &byte_odd;

    // Rounds 1, 2, 9 and 16 rotate by one, all others by two.
    function automatic logic [1:0] shift_amt(input logic [3:0] r);
        return (r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [0:27] rotl28(input logic [0:27] v, input logic [1:0] n);
        return (n == 2'd2) ? {v[2:27], v[0:1]} : {v[1:27], v[0]};
    endfunction

    function automatic logic [0:27] rotr28(input logic [0:27] v, input logic [1:0] n);
        return (n == 2'd2) ? {v[26:27], v[0:25]} : {v[27], v[0:26]};
    endfunction

    function automatic logic [0:55] rot_cd(input logic [0:55] v, input logic [1:0] n,
                                           input logic right);
        if (right) return {rotr28(v[0:27], n), rotr28(v[28:55], n)};
        else       return {rotl28(v[0:27], n), rotl28(v[28:55], n)};
    endfunction

    always_comb begin
        state_d   = state_q;
        cd_d      = cd_q;
        dec_d     = dec_q;
        round_d   = round_q;
        key_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (key_valid) begin
                    if (PARITY_CHECK && !parity_ok) begin
                        key_err_d = 1'b1;
                    end else begin
                        // Decrypt starts from C0D0, which equals C16D16 after 28 total shifts.
                        cd_d    = decrypt ? pc1_out : rot_cd(pc1_out, 2'd1, 1'b0);
                        dec_d   = decrypt;
                        round_d = 4'd0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    round_d = 4'd0;
                end else if (subkey_ready) begin
                    if (round_q == 4'd15) begin
                        state_d = StIdle;
                        round_d = 4'd0;
                    end else begin
                        cd_d = dec_q ? rot_cd(cd_q, shift_amt(4'd15 - round_q), 1'b1)
                                     : rot_cd(cd_q, shift_amt(round_q + 4'd1), 1'b0);
                        round_d = round_q + 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cd_q      <= '0;
            dec_q     <= 1'b0;
            round_q   <= 4'd0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cd_q      <= cd_d;
            dec_q     <= dec_d;
            round_q   <= round_d;
            key_err_q <= key_err_d;
        end
    end

    assign key_ready    = (state_q == StIdle);
    assign busy         = (state_q == StRun);
    assign subkey_valid = (state_q == StRun);
    assign round_idx    = round_q;
    assign last         = subkey_valid && (round_q == 4'd15);
    assign key_err      = key_err_q;
    assign subkey       = pc2_out;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Randomized self-checking bench for des_key_sched_ctrl against a direct DES key-schedule model
// (cumulative-shift C/D construction, one subkey per round index).
module tb_des_key_sched_ctrl;

    localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1_STD  = 48'h1B02EFFC7072;
    localparam logic [47:0] K16_STD = 48'hCB3D8B0E17F5;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        key_valid, decrypt, abort, subkey_ready;
    logic [63:0] key_in;
    logic        key_ready, subkey_valid, last, key_err, busy;
    logic [47:0] subkey;
    logic [3:0]  round_idx;

    logic        p_key_valid, p_decrypt, p_abort, p_subkey_ready;
    logic [63:0] p_key_in;
    logic        p_key_ready, p_subkey_valid, p_last, p_key_err, p_busy;
    logic [47:0] p_subkey;
    logic [3:0]  p_round_idx;

    int          n_vec = 0;
    int          n_err = 0;
    logic [47:0] got_k [16];
    logic [47:0] enc_k [16];

    des_key_sched_ctrl #(.PARITY_CHECK(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
        .key_in(key_in), .decrypt(decrypt), .abort(abort), .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready), .subkey(subkey), .round_idx(round_idx), .last(last),
        .key_err(key_err), .busy(busy)
    );

    des_key_sched_ctrl #(.PARITY_CHECK(1'b1)) dut_par (
        .clk(clk), .rst_n(rst_n), .key_valid(p_key_valid), .key_ready(p_key_ready),
        .key_in(p_key_in), .decrypt(p_decrypt), .abort(p_abort), .subkey_valid(p_subkey_valid),
        .subkey_ready(p_subkey_ready), .subkey(p_subkey), .round_idx(p_round_idx),
        .last(p_last), .key_err(p_key_err), .busy(p_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Subkey Kk (k = 1..16) built directly from the total left shift applied to C0/D0.
    function automatic logic [47:0] model_subkey(input logic [63:0] key, input int k);
        logic [55:0] cd0;
        logic [55:0] cdk;
        logic [47:0] sk;
        int          tot = 0;
        for (int p = 1; p <= 56; p++) cd0[56-p] = key[64-PC1[p-1]];
        for (int j = 0; j < k; j++) tot += SHIFTS[j];
        for (int p = 1; p <= 28; p++) begin
            cdk[56-p] = cd0[56-(((p - 1 + tot) % 28) + 1)];
            cdk[28-p] = cd0[28-(((p - 1 + tot) % 28) + 1)];
        end
        for (int p = 1; p <= 48; p++) sk[48-p] = cdk[56-PC2[p-1]];
        return sk;
    endfunction

    function automatic bit parity_bad(input logic [63:0] key);
        for (int b = 0; b < 8; b++) begin
            if ($countones(key[8*b +: 8]) % 2 == 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic run_key(input logic [63:0] key, input bit dec, input bit rand_ready,
                           input int stall_at, input int abort_at, input int rst_at,
                           input bit abort_on_accept);
        logic [47:0] exp_k [16];
        int          h = 0;
        int          cyc = 0;
        int          stall = 0;
        bit          rdy;
        bit          stopped = 1'b0;
        for (int j = 0; j < 16; j++) exp_k[j] = model_subkey(key, dec ? 16 - j : j + 1);
        while (!key_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("idle_before_accept", 64'({key_ready, subkey_valid}), 64'(2'b10));
        key_valid = 1'b1;
        key_in    = key;
        decrypt   = dec;
        abort     = abort_on_accept;
        @(posedge clk); #1;
        key_valid = 1'b0;
        abort     = 1'b0;
        key_in    = {$urandom, $urandom};
        decrypt   = ~dec;
        cyc       = 0;
        while (h < 16 && !stopped && cyc < 400) begin
            cyc++;
            if (stall_at == h && stall < 5) begin
                rdy = 1'b0;
                stall++;
            end else begin
                rdy = rand_ready ? bit'($urandom_range(0, 1)) : 1'b1;
            end
            check_eq($sformatf("round h=%0d", h),
                     64'({key_ready, busy, subkey_valid, last, round_idx, subkey}),
                     64'({1'b0, 1'b1, 1'b1, (h == 15), 4'(h), exp_k[h]}));
            got_k[h] = subkey;
            if (rst_at == h) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("async_reset_clear",
                         64'({busy, subkey_valid, last, round_idx, subkey, key_err}), 64'(0));
                @(negedge clk) rst_n = 1'b1;
                @(posedge clk); #1;
                check_eq("after_reset_idle", 64'({key_ready, subkey_valid}), 64'(2'b10));
                stopped = 1'b1;
            end else begin
                subkey_ready = rdy;
                abort        = (abort_at == h);
                @(posedge clk); #1;
                if (abort_at == h) begin
                    abort = 1'b0;
                    check_eq("abort_to_idle",
                             64'({key_ready, busy, subkey_valid, last, round_idx}),
                             64'({1'b1, 1'b0, 1'b0, 1'b0, 4'd0}));
                    stopped = 1'b1;
                end else if (rdy) begin
                    h++;
                end
            end
        end
        subkey_ready = 1'b0;
        if (!stopped) begin
            check_eq("handshake_count", 64'(h), 64'(16));
            check_eq("idle_after_last", 64'({key_ready, busy, subkey_valid, round_idx}),
                     64'({1'b1, 1'b0, 1'b0, 4'd0}));
        end
    endtask

    task automatic run_parity(input logic [63:0] key);
        bit exp_err = parity_bad(key);
        check_eq("par_idle", 64'({p_key_ready, p_subkey_valid}), 64'(2'b10));
        p_key_valid = 1'b1;
        p_key_in    = key;
        @(posedge clk); #1;
        p_key_valid = 1'b0;
        if (exp_err) begin
            check_eq("par_reject", 64'({p_key_err, p_subkey_valid, p_key_ready, p_busy}),
                     64'(4'b1010));
            @(posedge clk); #1;
            check_eq("par_pulse_end", 64'({p_key_err, p_subkey_valid, p_key_ready}),
                     64'(3'b001));
        end else begin
            for (int h = 0; h < 16; h++) begin
                check_eq($sformatf("par_round h=%0d", h),
                         64'({p_subkey_valid, p_key_err, p_last, p_round_idx, p_subkey}),
                         64'({1'b1, 1'b0, (h == 15), 4'(h), model_subkey(key, h + 1)}));
                @(posedge clk); #1;
            end
            check_eq("par_done", 64'({p_key_ready, p_subkey_valid}), 64'(2'b10));
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        key_valid      = 1'b0;
        key_in         = '0;
        decrypt        = 1'b0;
        abort          = 1'b0;
        subkey_ready   = 1'b0;
        p_key_valid    = 1'b0;
        p_key_in       = '0;
        p_decrypt      = 1'b0;
        p_abort        = 1'b0;
        p_subkey_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_state",
                 64'({busy, subkey_valid, last, round_idx, subkey, key_err}), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("ready_after_reset", 64'({key_ready, subkey_valid}), 64'(2'b10));

        run_key(KEY_STD, 1'b0, 1'b0, -1, -1, -1, 1'b0);
        enc_k = got_k;
        check_eq("enc_first_k1", 64'(got_k[0]), 64'(K1_STD));
        check_eq("enc_last_k16", 64'(got_k[15]), 64'(K16_STD));

        run_key(KEY_STD, 1'b1, 1'b0, -1, -1, -1, 1'b0);
        check_eq("dec_first_k16", 64'(got_k[0]), 64'(K16_STD));
        check_eq("dec_last_k1", 64'(got_k[15]), 64'(K1_STD));
        for (int j = 0; j < 16; j++)
            check_eq($sformatf("dec_reverse j=%0d", j), 64'(got_k[j]), 64'(enc_k[15-j]));

        run_key(KEY_STD, 1'b0, 1'b1, 3, -1, -1, 1'b0);
        for (int j = 0; j < 16; j++)
            check_eq($sformatf("stall_same j=%0d", j), 64'(got_k[j]), 64'(enc_k[j]));

        // Abort at round 7, then a new key in the very next cycle with abort held in IDLE.
        run_key(KEY_STD, 1'b0, 1'b0, -1, 7, -1, 1'b0);
        run_key({$urandom, $urandom}, bit'($urandom_range(0, 1)), 1'b1, -1, -1, -1, 1'b1);

        run_key(KEY_STD, 1'b1, 1'b0, -1, -1, 10, 1'b0);
        run_key(KEY_STD, 1'b0, 1'b0, -1, -1, -1, 1'b0);
        for (int j = 0; j < 16; j++)
            check_eq($sformatf("post_reset j=%0d", j), 64'(got_k[j]), 64'(enc_k[j]));

        for (int i = 0; i < 6; i++)
            run_key({$urandom, $urandom}, bit'($urandom_range(0, 1)), 1'b1,
                    int'($urandom_range(0, 15)), -1, -1, 1'b0);

        // Every byte of KEY_STD has odd parity, so it is accepted like the all-0x01 key.
        run_parity(64'h123457799BBCDFF1);
        run_parity(64'h0101010101010101);
        run_parity(KEY_STD);
        for (int i = 0; i < 3; i++) run_parity({$urandom, $urandom});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
